// File: rtl/dmem_bus_bridge.sv
// Bridges the level-held data-memory request interface onto a registered valid/ready bus
// with one outstanding transaction. Optional response timeout: define DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_DM_Wd,
  input  logic [DATA_W-1:0] i_DM_Addr,
  input  logic              i_DM_Wen,
  input  logic              i_DM_MemRead,
  input  logic [3:0]        i_DM_byte_en,
  output logic [DATA_W-1:0] o_DM_ReadData,
  output logic              o_DM_data_ready,
  output logic              o_bus_req_valid,
  input  logic              i_bus_req_ready,
  output logic              o_bus_we,
  output logic [DATA_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_rsp_valid,
  input  logic [DATA_W-1:0] i_bus_rsp_data,
  input  logic              i_bus_rsp_err,
  output logic              o_bus_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;
  logic              w_take_rsp;
  logic              w_take_to;
  logic              w_timeout;

  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_req_valid;
  logic              r_data_ready;
  logic              r_bus_err;
  logic              r_busy;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dmem_bus_bridge: TIMEOUT_CYCLES must be within 1..65535");
  end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;

  // Counts RESP cycles; held at zero elsewhere so it restarts on every entry to RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= 16'd0;
    end else if (r_state == ST_RESP) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt <= 16'd0;
    end
  end

  assign w_timeout = (r_state == ST_RESP) && (r_to_cnt == LP_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode; a response always wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_take_rsp  = 1'b0;
    w_take_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_DM_Wen || i_DM_MemRead) begin
          w_state_nxt = ST_REQ;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (r_req_valid && i_bus_req_ready) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_RESP: begin
        if (i_bus_rsp_valid) begin
          w_state_nxt = ST_DONE;
          w_take_rsp  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_take_to   = 1'b1;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_req_valid  <= 1'b0;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_valid  <= (w_state_nxt == ST_REQ);
      r_data_ready <= (w_state_nxt == ST_DONE);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  // Request registers; only loaded in IDLE so the bus fields stay stable through REQ.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'd0;
    end else if (w_capture) begin
      r_we    <= i_DM_Wen;
      r_addr  <= i_DM_Addr;
      r_wdata <= i_DM_Wd;
      r_be    <= i_DM_byte_en;
    end else begin
      r_we    <= r_we;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
      r_be    <= r_be;
    end
  end

  // Completion data: read data only changes for reads, the error flag pulses with data_ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else if (w_take_rsp) begin
      r_rdata   <= r_we ? r_rdata : i_bus_rsp_data;
      r_bus_err <= i_bus_rsp_err;
    end else if (w_take_to) begin
      r_rdata   <= r_we ? r_rdata : '0;
      r_bus_err <= 1'b1;
    end else begin
      r_rdata   <= r_rdata;
      r_bus_err <= 1'b0;
    end
  end

  assign o_DM_ReadData   = r_rdata;
  assign o_DM_data_ready = r_data_ready;
  assign o_bus_req_valid = r_req_valid;
  assign o_bus_we        = r_we;
  assign o_bus_addr      = r_addr;
  assign o_bus_wdata     = r_wdata;
  assign o_bus_be        = r_be;
  assign o_bus_err       = r_bus_err;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge: the bench plays both the DM stage and the bus slave,
// predicting every output cycle by cycle from the transaction-level rules.
module tb_dmem_bus_bridge;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_DM_Wd = 32'd0;
  logic [31:0] i_DM_Addr = 32'd0;
  logic        i_DM_Wen = 1'b0;
  logic        i_DM_MemRead = 1'b0;
  logic [3:0]  i_DM_byte_en = 4'd0;
  logic [31:0] o_DM_ReadData;
  logic        o_DM_data_ready;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready = 1'b0;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_rsp_valid = 1'b0;
  logic [31:0] i_bus_rsp_data = 32'd0;
  logic        i_bus_rsp_err = 1'b0;
  logic        o_bus_err;
  logic        o_busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata = 32'd0;

  dmem_bus_bridge #(.DATA_W(32), .TIMEOUT_CYCLES(8)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_DM_Wd(i_DM_Wd), .i_DM_Addr(i_DM_Addr), .i_DM_Wen(i_DM_Wen),
    .i_DM_MemRead(i_DM_MemRead), .i_DM_byte_en(i_DM_byte_en),
    .o_DM_ReadData(o_DM_ReadData), .o_DM_data_ready(o_DM_data_ready),
    .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_be(o_bus_be), .i_bus_rsp_valid(i_bus_rsp_valid),
    .i_bus_rsp_data(i_bus_rsp_data), .i_bus_rsp_err(i_bus_rsp_err),
    .o_bus_err(o_bus_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_rdata"}, o_DM_ReadData, 32'd0);
    check_value({tag, "_dready"}, {31'd0, o_DM_data_ready}, 32'd0);
    check_value({tag, "_valid"}, {31'd0, o_bus_req_valid}, 32'd0);
    check_value({tag, "_we"}, {31'd0, o_bus_we}, 32'd0);
    check_value({tag, "_addr"}, o_bus_addr, 32'd0);
    check_value({tag, "_wdata"}, o_bus_wdata, 32'd0);
    check_value({tag, "_be"}, {28'd0, o_bus_be}, 32'd0);
    check_value({tag, "_err"}, {31'd0, o_bus_err}, 32'd0);
    check_value({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  // One complete transaction; rsp_dly = extra RESP cycles before the response arrives.
  task automatic run_txn(input logic wen, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int rdy_dly, input int rsp_dly,
                         input logic [31:0] rdata, input logic err, input logic drop);
    i_DM_Wen = wen; i_DM_MemRead = rd; i_DM_Addr = addr; i_DM_Wd = wdata; i_DM_byte_en = be;
    tick();
    for (int k = 0; k <= rdy_dly; k++) begin
      check_value("req_valid", {31'd0, o_bus_req_valid}, 32'd1);
      check_value("req_we", {31'd0, o_bus_we}, {31'd0, wen});
      check_value("req_addr", o_bus_addr, addr);
      check_value("req_wdata", o_bus_wdata, wdata);
      check_value("req_be", {28'd0, o_bus_be}, {28'd0, be});
      check_value("req_dready", {31'd0, o_DM_data_ready}, 32'd0);
      check_value("req_busy", {31'd0, o_busy}, 32'd1);
      if (drop && k == 0) begin
        i_DM_Wen = 1'b0; i_DM_MemRead = 1'b0;
        i_DM_Addr = $urandom(); i_DM_Wd = $urandom(); i_DM_byte_en = 4'($urandom());
      end
      i_bus_req_ready = (k == rdy_dly);
      tick();
    end
    i_bus_req_ready = 1'b0;
    check_value("resp_valid_low", {31'd0, o_bus_req_valid}, 32'd0);
    for (int k = 0; k < rsp_dly; k++) begin
      check_value("resp_dready", {31'd0, o_DM_data_ready}, 32'd0);
      check_value("resp_busy", {31'd0, o_busy}, 32'd1);
      tick();
    end
    i_bus_rsp_valid = 1'b1; i_bus_rsp_data = rdata; i_bus_rsp_err = err;
    tick();
    i_bus_rsp_valid = 1'b0; i_bus_rsp_data = $urandom(); i_bus_rsp_err = 1'b0;
    if (!wen) exp_rdata = rdata;
    check_value("done_dready", {31'd0, o_DM_data_ready}, 32'd1);
    check_value("done_err", {31'd0, o_bus_err}, {31'd0, err});
    check_value("done_rdata", o_DM_ReadData, exp_rdata);
    check_value("done_valid", {31'd0, o_bus_req_valid}, 32'd0);
    i_DM_Wen = 1'b0; i_DM_MemRead = 1'b0;
    tick();
    check_value("idle_dready", {31'd0, o_DM_data_ready}, 32'd0);
    check_value("idle_err", {31'd0, o_bus_err}, 32'd0);
    check_value("idle_busy", {31'd0, o_busy}, 32'd0);
    check_value("idle_rdata", o_DM_ReadData, exp_rdata);
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Minimum-latency read.
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    // Write with ready stalled for 4 cycles.
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0000_AB00, 4'b0010, 4, 1, 32'h5555_5555, 1'b0, 1'b0);
    // Wen and MemRead together: write wins.
    run_txn(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 0, 32'h7777_7777, 1'b0, 1'b0);
    // Read with bus error.
    run_txn(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'hF, 1, 2, 32'hA5A5_0F0F, 1'b1, 1'b0);
    // Upstream drops its request while the bus is stalled: still completes.
    run_txn(1'b0, 1'b1, 32'h0000_0404, 32'h0, 4'h3, 2, 0, 32'h0BAD_F00D, 1'b0, 1'b1);

    // Reset while in RESP, then a late response must be ignored.
    i_DM_MemRead = 1'b1; i_DM_Addr = 32'h0000_0800;
    tick();
    i_bus_req_ready = 1'b1;
    tick();
    i_bus_req_ready = 1'b0;
    i_rst = 1'b1;
    #1;
    check_all_zero("rst_in_resp");
    exp_rdata = 32'd0;
    tick();
    i_rst = 1'b0; i_DM_MemRead = 1'b0;
    i_bus_rsp_valid = 1'b1; i_bus_rsp_data = 32'h1234_5678; i_bus_rsp_err = 1'b1;
    tick();
    i_bus_rsp_valid = 1'b0; i_bus_rsp_err = 1'b0;
    check_all_zero("late_rsp");
    run_txn(1'b0, 1'b1, 32'h0000_0900, 32'h0, 4'hF, 0, 0, 32'hC0DE_0001, 1'b0, 1'b0);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // No response: timeout after 8 RESP cycles, read data forced to 0.
    i_DM_MemRead = 1'b1; i_DM_Addr = 32'h0000_0A00;
    tick();
    i_bus_req_ready = 1'b1;
    tick();
    i_bus_req_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check_value("to_wait_dready", {31'd0, o_DM_data_ready}, 32'd0);
      tick();
    end
    check_value("to_wait_last", {31'd0, o_DM_data_ready}, 32'd0);
    tick();
    i_DM_MemRead = 1'b0;
    exp_rdata = 32'd0;
    check_value("to_dready", {31'd0, o_DM_data_ready}, 32'd1);
    check_value("to_err", {31'd0, o_bus_err}, 32'd1);
    check_value("to_rdata", o_DM_ReadData, 32'd0);
    tick();
    i_bus_rsp_valid = 1'b1; i_bus_rsp_data = 32'hFFFF_0000;
    tick();
    i_bus_rsp_valid = 1'b0;
    check_value("to_late_busy", {31'd0, o_busy}, 32'd0);
    check_value("to_late_dready", {31'd0, o_DM_data_ready}, 32'd0);
    // Response on the timeout cycle: normal completion.
    run_txn(1'b0, 1'b1, 32'h0000_0B00, 32'h0, 4'hF, 0, 7, 32'hCAFE_F00D, 1'b0, 1'b0);
`endif

    // Randomized back-to-back traffic.
    for (int t = 0; t < 40; t++) begin
      logic        wen;
      logic        rd;
      wen = 1'($urandom_range(0, 1));
      rd  = wen ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(wen, rd, $urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom()),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom(),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
